// File: rtl/serv_rf_ram_resp.sv
// serv_rf_ram_resp: RAM-side responder for the SERV register-file SRAM port.
// Word array with one write and one read port. Read data is registered and
// has one cycle of latency. After reset, a zero sweep clears every word
// before any requests are served.
// Optional feature macro: RF_RAM_PARITY_EN stores an even-parity bit per
// word and reports a mismatch on o_perr.
module serv_rf_ram_resp #(
  parameter  int width    = 16,
  parameter  int csr_regs = 4,
  localparam int depth    = 32 * (32 + csr_regs) / width,
  localparam int aw       = 5 + $clog2(32 + csr_regs) - $clog2(width)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic             o_init_done,
  input  logic             i_perr_inj,
  output logic             o_perr
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_next;
  logic [aw-1:0]    cnt;
  logic [width-1:0] mem [depth];
  logic             init, last;
  logic             wr_valid, rd_valid;
  logic             wr_en;
  logic [aw-1:0]    wr_addr;
  logic [width-1:0] wr_data;

  assign init = (state == INIT);
  assign last = (cnt == aw'(depth - 1));

  // Extra top bit keeps the range compare correct even if depth == 2**aw.
  assign wr_valid = ({1'b0, i_waddr} < (aw + 1)'(depth));
  assign rd_valid = ({1'b0, i_raddr} < (aw + 1)'(depth));

  // State register; reset always restarts the sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= INIT;
    else          state <= state_next;
  end

  // Next state: leave INIT on the cycle that clears the last word.
  always_comb begin
    state_next = state;
    if (state == INIT && last) state_next = RUN;
  end

  // Outputs of the FSM: write-port steering and init status.
  always_comb begin
    o_init_done = (state == RUN);
    wr_en       = 1'b0;
    wr_addr     = i_waddr;
    wr_data     = i_wdata;
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
      wr_data = '0;
    end else begin
      wr_en = i_wen && wr_valid;
    end
  end

  // Sweep counter walks addresses 0..depth-1 while in INIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  cnt <= '0;
    else if (init) cnt <= cnt + 1'b1;
  end

  // Array write; contents are only cleared by the sweep, never by reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read, read-before-write on address collision; holds when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   o_rdata <= '0;
    else if (init)  o_rdata <= '0;
    else if (i_ren) o_rdata <= rd_valid ? mem[i_raddr] : '0;
  end

`ifdef RF_RAM_PARITY_EN
  logic par [depth];
  logic wr_par;

  // Sweep stores even parity of zero; injection flips the stored bit.
  assign wr_par = init ? 1'b0 : ((^i_wdata) ^ i_perr_inj);

  // Parity array shares the write port with the data array.
  always_ff @(posedge i_clk) begin
    if (wr_en) par[wr_addr] <= wr_par;
  end

  // Parity check result, updated on the same edge as o_rdata.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   o_perr <= 1'b0;
    else if (init)  o_perr <= 1'b0;
    else if (i_ren) o_perr <= rd_valid ? ((^mem[i_raddr]) != par[i_raddr]) : 1'b0;
  end
`else
  logic unused_perr_inj;

  assign o_perr          = 1'b0;
  assign unused_perr_inj = i_perr_inj;
`endif

endmodule
